// File: rtl/felix_pkg.sv
// Shared constants and types for the FELIX frame builder and its CRC-20 step.
// The receive-side checker imports the same definitions.
package felix_pkg;

    localparam logic [31:0] IDLE_W = 32'h0000_00BC;
    localparam logic [31:0] SOF_W  = 32'h0000_003C;
    localparam logic [31:0] EOF_W  = 32'h0000_00DC;
    localparam logic [3:0]  IDLE_K = 4'b0001;
    localparam logic [3:0]  SOF_K  = 4'b0001;
    localparam logic [3:0]  EOF_K  = 4'b0001;
    localparam logic [3:0]  DATA_K = 4'b0000;

    localparam logic [19:0] CRC_INIT = 20'hFFFFF;
    // x^20 term is implicit; bits 0,1,2,3,6,7,9,11,12,18,19
    localparam logic [19:0] CRC_POLY = 20'hC1ACF;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SOF     = 3'd1,
        PAYLOAD = 3'd2,
        CRC     = 3'd3,
        EOF     = 3'd4
    } state_t;

endpackage

// File: rtl/felix_frame_builder_if.sv
// Payload input handshake plus the registered word/K-flag output towards the GT.
// slave is the frame builder; master is whatever feeds payload and watches the wire.
interface felix_frame_builder_if;

    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] m_data;
    logic [3:0]  m_k;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready,
        input  m_data,
        input  m_k
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready,
        output m_data,
        output m_k
    );

endinterface

// File: rtl/felix_crc20_step.sv
// One 32-bit step of the link CRC-20, data consumed MSB first.
// Purely combinational so the receive-side checker can share it.
module felix_crc20_step
    import felix_pkg::*;
(
    input  logic [19:0] crc,
    input  logic [31:0] data,
    output logic [19:0] crc_next
);

    logic [19:0] c;

    always_comb begin
        c = crc;
        for (int i = 31; i >= 0; i--) begin
            if (c[19] ^ data[i]) begin
                c = {c[18:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[18:0], 1'b0};
            end
        end
    end

    assign crc_next = c;

endmodule

// File: rtl/felix_frame_builder.sv
// Wraps WIB payload words into SOF / payload / CRC-20 / EOF link frames
// with K28.5 idles between frames and during payload underruns.
//
// state   | meaning
// IDLE    | idle word on the wire, waiting for s_valid
// SOF     | start-of-frame word, CRC and word counter restart
// PAYLOAD | accepting payload; idle + underrun pulse when s_valid is low
// CRC     | CRC-20 trailer word
// EOF     | end-of-frame word, frame counter advances
module felix_frame_builder
    import felix_pkg::*;
#(
    parameter int FRAME_WORDS = 116,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    felix_frame_builder_if.slave bus,
    output logic [CNT_W-1:0]     frame_cnt,
    output logic                 underrun
);

    localparam int WC_W = $clog2(FRAME_WORDS);
    localparam logic [WC_W-1:0] LAST = WC_W'(FRAME_WORDS - 1);

    state_t          state;
    logic [19:0]     crc_reg;
    logic [19:0]     crc_next;
    logic [WC_W-1:0] word_cnt;

    felix_crc20_step u_crc (
        .crc      (crc_reg),
        .data     (bus.s_data),
        .crc_next (crc_next)
    );

    // Decoded from the state register only, never from s_valid.
    assign bus.s_ready = (state == PAYLOAD);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            bus.m_data <= IDLE_W;
            bus.m_k    <= IDLE_K;
            crc_reg    <= CRC_INIT;
            word_cnt   <= '0;
            frame_cnt  <= '0;
            underrun   <= 1'b0;
        end else begin
            underrun <= 1'b0;
            unique case (state)
                IDLE: begin
                    bus.m_data <= IDLE_W;
                    bus.m_k    <= IDLE_K;
                    if (bus.s_valid) state <= SOF;
                end
                SOF: begin
                    bus.m_data <= SOF_W;
                    bus.m_k    <= SOF_K;
                    crc_reg    <= CRC_INIT;
                    word_cnt   <= '0;
                    state      <= PAYLOAD;
                end
                PAYLOAD: begin
                    if (bus.s_valid) begin
                        bus.m_data <= bus.s_data;
                        bus.m_k    <= DATA_K;
                        crc_reg    <= crc_next;
                        word_cnt   <= word_cnt + WC_W'(1);
                        if (word_cnt == LAST) state <= CRC;
                    end else begin
                        bus.m_data <= IDLE_W;
                        bus.m_k    <= IDLE_K;
                        underrun   <= 1'b1;
                    end
                end
                CRC: begin
                    bus.m_data <= {12'h000, crc_reg};
                    bus.m_k    <= DATA_K;
                    state      <= EOF;
                end
                EOF: begin
                    bus.m_data <= EOF_W;
                    bus.m_k    <= EOF_K;
                    frame_cnt  <= frame_cnt + CNT_W'(1);
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/felix_frame_builder.md
# felix_frame_builder

Builds FELIX link frames from a stream of 32-bit WIB payload words. Each frame is an SOF K-word, FRAME_WORDS payload words, a CRC-20 trailer word and an EOF K-word. K28.5 idle words fill every other cycle. The block sits directly upstream of the GT transmit interface and computes the CRC-20 inline, bit-exact with the team's crc20 block.

## Interface
- FRAME_WORDS, default 116: payload words per frame; legal range 2..1023.
- CNT_W, default 16: width of the frame counter.
- clk  in  1: link word clock.
- rst_n  in  1: reset, synchronous, active-low.
- s_data  in  32: payload word.
- s_valid  in  1: s_data is valid.
- s_ready  out  1: block accepts s_data this cycle. High only in PAYLOAD.
- m_data  out  32: word to the transceiver. Registered.
- m_k  out  4: per-byte K-character flags. Registered.
- frame_cnt  out  CNT_W: number of completed frames; wraps to 0.
- underrun  out  1: one-cycle pulse when an idle word is inserted mid-payload.

## Operation
- Constants:
  - IDLE_W = 32'h0000_00BC (K28.5), k = 4'b0001.
  - SOF_W = 32'h0000_003C (K28.1), k = 4'b0001.
  - EOF_W = 32'h0000_00DC (K28.6), k = 4'b0001.
  - Data and CRC words use k = 4'b0000.
- CRC:
  - Polynomial 1+x+x^2+x^3+x^6+x^7+x^9+x^11+x^12+x^18+x^19+x^20.
  - 32 data bits per step.
  - Next-state equations identical to crc20 for the same bit indices.
  - Register initialised to 20'hFFFFF.
- States and transitions:
  - IDLE: emit IDLE_W, s_ready=0. Go to SOF when s_valid=1.
  - SOF: emit SOF_W, load CRC register with 20'hFFFFF, clear word counter. Always go to PAYLOAD.
  - PAYLOAD: s_ready=1.
    - On s_valid: emit s_data, advance CRC with s_data, increment word counter.
    - On !s_valid: emit IDLE_W, pulse underrun. CRC and word counter hold.
    - Accepting word index FRAME_WORDS-1 goes to CRC.
  - CRC: emit {12'h000, crc_reg}, where crc_reg is the state after the last payload word. Go to EOF.
  - EOF: emit EOF_W, increment frame_cnt (modulo 2^CNT_W). Go to IDLE.
- Spacing: at least one IDLE_W separates consecutive frames, even when s_valid is held high.
- Word counter width: clog2(FRAME_WORDS).

## Timing
- A word accepted at cycle t appears on m_data/m_k at t+1.
- State advances on the accepting edge.
- Frame on the wire, with no underrun: 1 SOF + FRAME_WORDS data + 1 CRC + 1 EOF + at least 1 idle, i.e. FRAME_WORDS+4 cycles minimum per frame.
- CRC word is on m_data the cycle after the last data word. EOF follows one cycle later.
- s_ready is decoded from the registered state only, with no combinational path from s_valid.
- Reset, sampled on clk when rst_n=0:
  - state=IDLE, m_data=IDLE_W, m_k=4'b0001.
  - crc_reg=20'hFFFFF, word counter=0, frame_cnt=0, underrun=0, s_ready=0.
- Reset asserted mid-frame: the frame is abandoned with no EOF. The next cycle after release emits IDLE_W.
- s_valid is ignored outside PAYLOAD.
- s_data held during an underrun is not consumed twice.

## Structure
- Package felix_pkg:
  - K-word constants IDLE_W, SOF_W, EOF_W and their k masks.
  - State enum (IDLE, SOF, PAYLOAD, CRC, EOF).
  - CRC_INIT = 20'hFFFFF.
- Sub-module felix_crc20_step: purely combinational next-state function with inputs crc[19:0], data[31:0] and output crc_next[19:0]. It is reusable by the receive-side checker.
- The top level holds the FSM, counters and output registers.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, then release with s_valid=0 → m_data=0x000000BC, m_k=0001, s_ready=0, frame_cnt=0.
- Single frame, FRAME_WORDS=4, data 0x11111111..0x44444444 presented with s_valid continuously high:
  - m_data sequence: 0x3C, the 4 data words, CRC, 0xDC, 0xBC.
  - CRC equals the crc20 block on the bench fed the same 4 words from reset.
  - frame_cnt=1.
- Underrun: drop s_valid for 2 cycles after the 2nd payload word → two IDLE_W words inside the frame, two underrun pulses, CRC unchanged versus the no-gap case.
- Back-to-back: s_valid held high for 3 frames → exactly one 0xBC between each EOF and the next SOF, frame_cnt=3.
- Mid-frame reset: assert rst_n=0 during the 3rd payload word → next output 0xBC, no EOF. The following frame's CRC matches a clean run.
- Wrap: CNT_W=2, run 5 frames → frame_cnt steps 1,2,3,0,1.
